// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with hex glyphs, decimal points,
// leading-zero blanking, anode dead time and frame-synchronous updates.
module seg7_scan_driver #(
  parameter int DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW = 1'b1,
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  output logic [6:0]            segment,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     anode,
  output logic [IW-1:0]         digit_idx
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [6:0] SEG_INV = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_INV = {DIGITS{AN_ACTIVE_LOW}};
  localparam logic DP_INV = SEG_ACTIVE_LOW;

  logic [CW-1:0]       div_cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] sh_value;
  logic [4*DIGITS-1:0] pd_value;
  logic [DIGITS-1:0]   sh_dp;
  logic [DIGITS-1:0]   pd_dp;
  logic                sh_blz;
  logic                pd_blz;
  logic                pend_valid;

  logic                div_last;
  logic                frame_wrap;
  logic [DIGITS-1:0]   blank;
  logic [DIGITS-1:0]   onehot;
  logic                run;
  logic [3:0]          nib;
  logic                cur_dp;
  logic                cur_blank;
  logic [6:0]          cur_seg;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      4'hF: g = 7'b1000111;
    endcase
    return g;
  endfunction

  assign div_last = (div_cnt == DIV_LAST);
  assign frame_wrap = div_last && (idx == IDX_LAST);

  // Blanking runs from the top digit down and stops at the first non-zero.
  always_comb begin
    blank = '0;
    run = sh_blz;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run = run && (sh_value[4*i +: 4] == 4'h0);
      blank[i] = run;
    end
  end

  always_comb begin
    nib = 4'h0;
    cur_dp = 1'b0;
    cur_blank = 1'b0;
    onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib = sh_value[4*i +: 4];
        cur_dp = sh_dp[i];
        cur_blank = blank[i];
        onehot[i] = 1'b1;
      end
    end
    cur_seg = cur_blank ? 7'b0000000 : glyph(nib);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      idx <= '0;
      sh_value <= '0;
      sh_dp <= '0;
      sh_blz <= 1'b0;
      pd_value <= '0;
      pd_dp <= '0;
      pd_blz <= 1'b0;
      pend_valid <= 1'b0;
      segment <= SEG_INV;
      dp_out <= DP_INV;
      anode <= AN_INV;
      digit_idx <= '0;
    end else begin
      segment <= SEG_INV;
      dp_out <= DP_INV;
      anode <= AN_INV;
      if (!enable) begin
        div_cnt <= '0;
        idx <= '0;
        digit_idx <= '0;
        pend_valid <= 1'b0;
        if (load) begin
          sh_value <= value;
          sh_dp <= dp;
          sh_blz <= blank_lz;
        end else if (pend_valid) begin
          sh_value <= pd_value;
          sh_dp <= pd_dp;
          sh_blz <= pd_blz;
        end
      end else begin
        // div_cnt==0 is the dead-time cycle: everything stays dark.
        if (div_cnt != '0) begin
          anode <= onehot ^ AN_INV;
          segment <= cur_seg ^ SEG_INV;
          dp_out <= cur_dp ^ DP_INV;
          digit_idx <= idx;
        end
        if (div_last) begin
          div_cnt <= '0;
          idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
          div_cnt <= div_cnt + CW'(1);
        end
        if (frame_wrap && load) begin
          sh_value <= value;
          sh_dp <= dp;
          sh_blz <= blank_lz;
          pend_valid <= 1'b0;
        end else if (frame_wrap && pend_valid) begin
          sh_value <= pd_value;
          sh_dp <= pd_dp;
          sh_blz <= pd_blz;
          pend_valid <= 1'b0;
        end else if (load) begin
          pd_value <= value;
          pd_dp <= dp;
          pd_blz <= blank_lz;
          pend_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a DIGITS-digit common-anode/cathode 7-segment display.
- Latches a packed hex value and scans one digit per SCAN_DIV clocks, applying the team's standard hex glyph table.
- Adds per-digit decimal points, leading-zero blanking, anode dead time and tear-free frame-synchronous value updates.
- Sits between core debug/status registers and the board display pins.

Parameters:
- DIGITS, 4, number of digits scanned; legal 1..8.
- SCAN_DIV, 50000, clocks per digit slot; legal >= 2.
- SEG_ACTIVE_LOW, 1, 1 = segment and dp pins are driven low-true.
- AN_ACTIVE_LOW, 1, 1 = anode pins are driven low-true.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  scan enable; 0 blanks the display and parks the scan.
- load  in  1  1-cycle strobe; capture value/dp/blank_lz into pending.
- value  in  4*DIGITS  packed nibbles; nibble i (bits 4i+3:4i) = digit i; digit 0 = rightmost.
- dp  in  DIGITS  decimal point request per digit.
- blank_lz  in  1  leading-zero blanking request.
- segment  out  7  bit6=a … bit0=g, polarity per SEG_ACTIVE_LOW.
- dp_out  out  1  decimal point pin, polarity per SEG_ACTIVE_LOW.
- anode  out  DIGITS  one-hot digit select, polarity per AN_ACTIVE_LOW.
- digit_idx  out  $clog2(DIGITS) (min 1)  index of the digit currently shown.

Behaviour:
- Reset and outputs:
  - Reset is synchronous, active-high, and takes priority over everything.
  - On reset: div_cnt=0, idx=0, shadow value/dp/blank_lz=0, pend_valid=0.
  - All outputs reset to the inactive level: segment, dp_out and anode all-inactive; digit_idx=0.
- Glyphs (active-high form, before polarity):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Scan counters:
  - div_cnt counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1, div_cnt wraps to 0 and idx advances; idx wraps from DIGITS-1 to 0.
- Registered outputs:
  - All outputs are registered and are a function of the pre-update div_cnt/idx/shadow, giving 1-cycle latency.
  - Dead time: when div_cnt==0, anode is loaded all-inactive.
  - Otherwise anode is loaded with onehot(idx), and digit_idx is loaded with idx.
- Leading-zero blanking:
  - Digit i (i>0) is blanked when shadow blank_lz=1 and shadow nibbles DIGITS-1..i are all zero.
  - Digit 0 is never blanked.
  - A blanked digit outputs segment all-inactive; its dp_out still follows shadow dp[i].
- Load and pending:
  - load=1 captures value/dp/blank_lz into pending and sets pend_valid.
  - Shadow is the only source for display.
- Frame wrap:
  - Frame wrap = div_cnt==SCAN_DIV-1 and idx==DIGITS-1.
  - At frame wrap with pend_valid, shadow <= pending and pend_valid is cleared.
  - load coinciding with frame wrap: the new inputs go straight to shadow and pend_valid=0.
  - Multiple loads within one frame: the last one wins.
- Enable low:
  - enable=0 forces div_cnt=0, idx=0, and outputs all-inactive next cycle.
  - If pend_valid (or load present), shadow is updated immediately and pend_valid=0.
  - On re-enable, scanning restarts at digit 0 with its dead-time cycle.
- Polarity: pins are inverted when the corresponding ACTIVE_LOW parameter is 1; inversion is applied in the output register, so there is no extra latency.
- DIGITS=1: idx is constant 0; every slot still has one dead-time cycle.

Test Plan:
- Reset behaviour (DIGITS=4, SCAN_DIV=4, both ACTIVE_LOW=1): hold rst 3 cycles -> anode=4'b1111, segment=7'b1111111, dp_out=1, digit_idx=0.
- Basic scan: load value=16'h12AF, dp=0, enable=1, wait one frame -> slot for digit 0 shows segment=~7'b1000111; digit 3 shows ~7'b0110000 with anode=4'b0111.
  - Check each slot: 1 dead cycle with anode=4'b1111, then 3 active cycles.
- Leading-zero blanking: value=16'h0030, blank_lz=1, dp[3]=1 -> digits 3 and 2 segment=7'b1111111 while digit 3 still has dp_out=0; digit 1 shows ~1111001; digit 0 shows ~1111110.
- Tear-free update: load 16'h1111, then load 16'h2222 mid-frame at idx=1 -> the current frame shows all 1s; the next frame shows all 2s. Also load exactly on the wrap cycle -> the new value appears in the next frame.
- Enable gating / reset mid-scan: drop enable at idx=2 -> next cycle all outputs inactive; re-enable -> digit 0 first after its dead cycle. Assert rst at idx=3 -> shadow is cleared and the display shows 0 on digit 0.
- Polarity variant: SEG_ACTIVE_LOW=0, AN_ACTIVE_LOW=0, value nibble 8 -> segment=7'b1111111, anode one-hot high; during dead time anode=0.
